// File: rtl/status_register.sv
// Processor status register (P) for a 6502-style core: six stored flags, a push
// image with B/bit5 synthesised, and a delayed interrupt mask.
module status_register #(
   parameter logic [7:0] RESET_P = 8'b0011_0100
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       alu_carry,
   input  logic       alu_zero,
   input  logic       alu_negative,
   input  logic       alu_overflow,
   input  logic [3:0] alu_flag_we,
   input  logic [7:0] db_in,
   input  logic       load_db,
   input  logic       bit_load,
   input  logic       set_c,
   input  logic       clr_c,
   input  logic       set_i,
   input  logic       clr_i,
   input  logic       set_d,
   input  logic       clr_d,
   input  logic       clr_v,
   input  logic       irq_entry,
   input  logic       push_brk,
   output logic [7:0] p_push,
   output logic       flag_n,
   output logic       flag_v,
   output logic       flag_d,
   output logic       flag_i,
   output logic       flag_z,
   output logic       flag_c,
   output logic       irq_mask
);

   logic n_q, v_q, d_q, i_q, z_q, c_q, irq_mask_q;
   logic n_d, v_d, d_d, i_d, z_d, c_d, irq_mask_d;

   // Later assignments override earlier ones, so each flag's sources are
   // listed from lowest to highest priority.
   always_comb begin
      n_d        = n_q;
      v_d        = v_q;
      d_d        = d_q;
      i_d        = i_q;
      z_d        = z_q;
      c_d        = c_q;
      irq_mask_d = i_q;

      if (load_db) begin
         n_d = db_in[7];
         v_d = db_in[6];
         d_d = db_in[3];
         i_d = db_in[2];
         z_d = db_in[1];
         c_d = db_in[0];
      end else begin
         if (alu_flag_we[3]) n_d = alu_negative;
         if (alu_flag_we[2]) v_d = alu_overflow;
         if (alu_flag_we[1]) z_d = alu_zero;
         if (alu_flag_we[0]) c_d = alu_carry;

         if (bit_load) begin
            n_d = db_in[7];
            v_d = db_in[6];
         end
         if (clr_v) v_d = 1'b0;

         if (clr_c) c_d = 1'b0;
         if (set_c) c_d = 1'b1;
         if (clr_d) d_d = 1'b0;
         if (set_d) d_d = 1'b1;
         if (clr_i) i_d = 1'b0;
         if (set_i) i_d = 1'b1;

         // Interrupt entry masks immediately rather than after the usual lag.
         if (irq_entry) begin
            i_d        = 1'b1;
            irq_mask_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         n_q        <= RESET_P[7];
         v_q        <= RESET_P[6];
         d_q        <= RESET_P[3];
         i_q        <= RESET_P[2];
         z_q        <= RESET_P[1];
         c_q        <= RESET_P[0];
         irq_mask_q <= 1'b1;
      end else begin
         n_q        <= n_d;
         v_q        <= v_d;
         d_q        <= d_d;
         i_q        <= i_d;
         z_q        <= z_d;
         c_q        <= c_d;
         irq_mask_q <= irq_mask_d;
      end
   end

   assign flag_n   = n_q;
   assign flag_v   = v_q;
   assign flag_d   = d_q;
   assign flag_i   = i_q;
   assign flag_z   = z_q;
   assign flag_c   = c_q;
   assign irq_mask = irq_mask_q;
   assign p_push   = {n_q, v_q, 1'b1, push_brk, d_q, i_q, z_q, c_q};

endmodule

// File: tb/tb_status_register.sv
// Bench for status_register: directed scenarios followed by randomized cycles
// checked against a byte-level model of the P register.
module tb_status_register;

   localparam logic [7:0] RESET_P = 8'b0011_0100;

   logic       clk;
   logic       rst;
   logic       alu_carry, alu_zero, alu_negative, alu_overflow;
   logic [3:0] alu_flag_we;
   logic [7:0] db_in;
   logic       load_db, bit_load;
   logic       set_c, clr_c, set_i, clr_i, set_d, clr_d, clr_v;
   logic       irq_entry, push_brk;
   logic [7:0] p_push;
   logic       flag_n, flag_v, flag_d, flag_i, flag_z, flag_c, irq_mask;

   int n_tests;
   int n_fail;

   // Model: P held as a byte (bits 5:4 don't care) plus the mask bit.
   logic [7:0] m_p;
   logic       m_mask;

   status_register #(.RESET_P(RESET_P)) dut (
      .clk         (clk),
      .rst         (rst),
      .alu_carry   (alu_carry),
      .alu_zero    (alu_zero),
      .alu_negative(alu_negative),
      .alu_overflow(alu_overflow),
      .alu_flag_we (alu_flag_we),
      .db_in       (db_in),
      .load_db     (load_db),
      .bit_load    (bit_load),
      .set_c       (set_c),
      .clr_c       (clr_c),
      .set_i       (set_i),
      .clr_i       (clr_i),
      .set_d       (set_d),
      .clr_d       (clr_d),
      .clr_v       (clr_v),
      .irq_entry   (irq_entry),
      .push_brk    (push_brk),
      .p_push      (p_push),
      .flag_n      (flag_n),
      .flag_v      (flag_v),
      .flag_d      (flag_d),
      .flag_i      (flag_i),
      .flag_z      (flag_z),
      .flag_c      (flag_c),
      .irq_mask    (irq_mask)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic idle();
      rst          = 1'b0;
      alu_carry    = 1'b0;
      alu_zero     = 1'b0;
      alu_negative = 1'b0;
      alu_overflow = 1'b0;
      alu_flag_we  = 4'h0;
      db_in        = 8'h00;
      load_db      = 1'b0;
      bit_load     = 1'b0;
      set_c        = 1'b0;
      clr_c        = 1'b0;
      set_i        = 1'b0;
      clr_i        = 1'b0;
      set_d        = 1'b0;
      clr_d        = 1'b0;
      clr_v        = 1'b0;
      irq_entry    = 1'b0;
      push_brk     = 1'b0;
   endtask

   // Behavioural step: start from the current byte and overwrite bits in
   // increasing order of precedence.
   task automatic model_step();
      logic [7:0] p;
      logic       mask;
      if (rst) begin
         m_p    = RESET_P;
         m_mask = 1'b1;
         return;
      end
      p    = m_p;
      mask = m_p[2];
      if (load_db) begin
         p = db_in;
      end else begin
         if (alu_flag_we[3]) p[7] = alu_negative;
         if (alu_flag_we[2]) p[6] = alu_overflow;
         if (alu_flag_we[1]) p[1] = alu_zero;
         if (alu_flag_we[0]) p[0] = alu_carry;
         if (bit_load) p[7:6] = db_in[7:6];
         if (clr_v) p[6] = 1'b0;
         if (clr_c) p[0] = 1'b0;
         if (set_c) p[0] = 1'b1;
         if (clr_d) p[3] = 1'b0;
         if (set_d) p[3] = 1'b1;
         if (clr_i) p[2] = 1'b0;
         if (set_i) p[2] = 1'b1;
         if (irq_entry) begin
            p[2] = 1'b1;
            mask = 1'b1;
         end
      end
      m_p    = p;
      m_mask = mask;
   endtask

   task automatic compare_all();
      logic [7:0] exp_push;
      exp_push = {m_p[7:6], 1'b1, push_brk, m_p[3:0]};
      check("p_push", p_push, exp_push);
      check("flags", {flag_n, flag_v, 2'b00, flag_d, flag_i, flag_z, flag_c},
            {m_p[7:6], 2'b00, m_p[3:0]});
      check("irq_mask", {7'b0, irq_mask}, {7'b0, m_mask});
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      compare_all();
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      m_p     = 8'h00;
      m_mask  = 1'b0;
      idle();

      // Reset and the post-reset push image.
      rst = 1'b1;
      cycle();
      idle();
      check("reset_push", p_push, 8'h24);
      check("reset_mask", {7'b0, irq_mask}, 8'h01);

      // 0x80 + 0x80: C, Z, V set, N clear.
      alu_carry    = 1'b1;
      alu_zero     = 1'b1;
      alu_overflow = 1'b1;
      alu_negative = 1'b0;
      alu_flag_we  = 4'hF;
      cycle();
      idle();
      check("add_nvzc", {4'b0, flag_n, flag_v, flag_z, flag_c}, 8'h07);

      // Pull of 0xFF beats a simultaneous clr_c.
      load_db = 1'b1;
      db_in   = 8'hFF;
      clr_c   = 1'b1;
      cycle();
      idle();
      check("pull_push_b0", p_push, 8'hEF);
      push_brk = 1'b1;
      #1;
      check("pull_push_b1", p_push, 8'hFF);
      push_brk = 1'b0;

      // BIT: N/V from the bus, Z from the ALU, C untouched.
      bit_load    = 1'b1;
      db_in       = 8'b1000_0000;
      alu_zero    = 1'b1;
      alu_flag_we = 4'b0010;
      cycle();
      idle();
      check("bit_nvzc", {4'b0, flag_n, flag_v, flag_z, flag_c}, 8'h0B);

      // CLI: I drops now, mask follows a cycle later.
      clr_i = 1'b1;
      cycle();
      idle();
      check("cli_flag_i", {7'b0, flag_i}, 8'h00);
      check("cli_mask_lag", {7'b0, irq_mask}, 8'h01);
      cycle();
      check("cli_mask", {7'b0, irq_mask}, 8'h00);
      clr_i     = 1'b1;
      irq_entry = 1'b1;
      cycle();
      idle();
      check("irq_over_cli", {7'b0, flag_i}, 8'h01);
      check("irq_mask_now", {7'b0, irq_mask}, 8'h01);

      // set_d wins over clr_d; clr_v wins over ALU overflow.
      set_d = 1'b1;
      clr_d = 1'b1;
      cycle();
      idle();
      check("sed_cld_d", {7'b0, flag_d}, 8'h01);
      clr_v        = 1'b1;
      alu_overflow = 1'b1;
      alu_flag_we  = 4'b0100;
      cycle();
      idle();
      check("clv_over_alu", {7'b0, flag_v}, 8'h00);

      // Reset discards a concurrent pull.
      rst     = 1'b1;
      load_db = 1'b1;
      db_in   = 8'h00;
      cycle();
      idle();
      check("rst_over_pull", p_push, 8'h24);
      check("rst_mask", {7'b0, irq_mask}, 8'h01);

      for (int k = 0; k < 2000; k++) begin
         rst          = ($urandom_range(0, 39) == 0);
         alu_carry    = 1'($urandom);
         alu_zero     = 1'($urandom);
         alu_negative = 1'($urandom);
         alu_overflow = 1'($urandom);
         alu_flag_we  = 4'($urandom);
         db_in        = 8'($urandom);
         load_db      = ($urandom_range(0, 7) == 0);
         bit_load     = ($urandom_range(0, 5) == 0);
         set_c        = ($urandom_range(0, 7) == 0);
         clr_c        = ($urandom_range(0, 7) == 0);
         set_i        = ($urandom_range(0, 7) == 0);
         clr_i        = ($urandom_range(0, 5) == 0);
         set_d        = ($urandom_range(0, 7) == 0);
         clr_d        = ($urandom_range(0, 7) == 0);
         clr_v        = ($urandom_range(0, 7) == 0);
         irq_entry    = ($urandom_range(0, 9) == 0);
         push_brk     = 1'($urandom);
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
